// File: rtl/stacc_tone_player.sv
// -----------------------------------------------------------------------------
// stacc_tone_player
// Turns the staccato quaver gate from the rhythm clock into a square-wave tone.
// Each gate pulse plays the next entry of a fixed 16-entry half-period ROM.
// The tone sounds while the gate is high and is silent while it is low.
//
// Build option: define STACC_LOOP_EN to wrap from the last note back to
// note 0. Without it, the sequence stops in DONE after the last note and
// raises seq_done.
// -----------------------------------------------------------------------------
module stacc_tone_player #(
    parameter int NUM_NOTES  = 16,
    parameter int HALF_SHIFT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       gate_in,
    output logic       audio_out,
    output logic [3:0] note_idx,
    output logic       note_valid,
    output logic       seq_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_SOUND = 3'd2,
        ST_REST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(NUM_NOTES - 1);

    // Half-period table in clk cycles. Entry 8 is a rest.
    function automatic logic [16:0] rom_half(input logic [3:0] idx);
        logic [16:0] val;
        case (idx)
            4'd0:    val = 17'd95556;
            4'd1:    val = 17'd85131;
            4'd2:    val = 17'd75843;
            4'd3:    val = 17'd71586;
            4'd4:    val = 17'd63776;
            4'd5:    val = 17'd56818;
            4'd6:    val = 17'd50619;
            4'd7:    val = 17'd47778;
            4'd8:    val = 17'd0;
            4'd9:    val = 17'd50619;
            4'd10:   val = 17'd56818;
            4'd11:   val = 17'd63776;
            4'd12:   val = 17'd71586;
            4'd13:   val = 17'd75843;
            4'd14:   val = 17'd85131;
            4'd15:   val = 17'd95556;
            default: val = 17'd0;
        endcase
        return val;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        gate_meta_r, gate_sync_r, gate_dly_r;
    logic        rise_s, fall_s;
    logic [16:0] half_r, half_nxt_s, half_rom_s;
    logic [16:0] div_r, div_nxt_s;
    logic [3:0]  idx_r, idx_nxt_s;
    logic        audio_r, audio_nxt_s;
    logic        valid_r, valid_nxt_s;
    logic        done_r, done_nxt_s;
    state_t      adv_state_s;
    logic [3:0]  adv_idx_s;
    logic        adv_done_s;

    // Two-flop synchroniser for the asynchronous gate plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_meta_r <= 1'b0;
            gate_sync_r <= 1'b0;
            gate_dly_r  <= 1'b0;
        end else begin
            gate_meta_r <= gate_in;
            gate_sync_r <= gate_meta_r;
            gate_dly_r  <= gate_sync_r;
        end
    end

    assign rise_s     = gate_sync_r & ~gate_dly_r;
    assign fall_s     = ~gate_sync_r & gate_dly_r;
    assign half_rom_s = rom_half(idx_r) >> HALF_SHIFT;

    // Where a finished note leads: the next index, or the end-of-sequence handling.
    always_comb begin
        adv_state_s = ST_WAIT;
        adv_idx_s   = idx_r;
        adv_done_s  = 1'b0;
        if (idx_r == LAST_IDX) begin
`ifdef STACC_LOOP_EN
            adv_state_s = ST_WAIT;
            adv_idx_s   = 4'd0;
            adv_done_s  = 1'b0;
`else
            adv_state_s = ST_DONE;
            adv_idx_s   = idx_r;
            adv_done_s  = 1'b1;
`endif
        end else begin
            adv_idx_s = idx_r + 4'd1;
        end
    end

    // Next-state and next-output logic for the player FSM.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        half_nxt_s  = half_r;
        div_nxt_s   = div_r;
        audio_nxt_s = audio_r;
        valid_nxt_s = valid_r;
        done_nxt_s  = done_r;

        if (!enable) begin
            // Disable wins over everything; the index is kept unless leaving DONE.
            state_nxt_s = ST_IDLE;
            audio_nxt_s = 1'b0;
            valid_nxt_s = 1'b0;
            div_nxt_s   = 17'd0;
            if (state_r == ST_DONE) begin
                idx_nxt_s  = 4'd0;
                done_nxt_s = 1'b0;
            end else begin
                idx_nxt_s  = idx_r;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_WAIT;
                    audio_nxt_s = 1'b0;
                    valid_nxt_s = 1'b0;
                end
                ST_WAIT: begin
                    audio_nxt_s = 1'b0;
                    valid_nxt_s = 1'b0;
                    div_nxt_s   = 17'd0;
                    if (rise_s) begin
                        half_nxt_s = half_rom_s;
                        if (half_rom_s != 17'd0) begin
                            // Tone starts high on the edge that enters SOUND.
                            state_nxt_s = ST_SOUND;
                            audio_nxt_s = 1'b1;
                            valid_nxt_s = 1'b1;
                        end else begin
                            // Rest entry or shifted-to-zero period never toggles.
                            state_nxt_s = ST_REST;
                        end
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_SOUND: begin
                    if (fall_s) begin
                        state_nxt_s = adv_state_s;
                        idx_nxt_s   = adv_idx_s;
                        done_nxt_s  = adv_done_s;
                        audio_nxt_s = 1'b0;
                        valid_nxt_s = 1'b0;
                        div_nxt_s   = 17'd0;
                    end else if (div_r == (half_r - 17'd1)) begin
                        audio_nxt_s = ~audio_r;
                        div_nxt_s   = 17'd0;
                    end else begin
                        div_nxt_s   = div_r + 17'd1;
                    end
                end
                ST_REST: begin
                    audio_nxt_s = 1'b0;
                    valid_nxt_s = 1'b0;
                    if (fall_s) begin
                        state_nxt_s = adv_state_s;
                        idx_nxt_s   = adv_idx_s;
                        done_nxt_s  = adv_done_s;
                    end else begin
                        state_nxt_s = ST_REST;
                    end
                end
                ST_DONE: begin
                    audio_nxt_s = 1'b0;
                    valid_nxt_s = 1'b0;
                    done_nxt_s  = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    audio_nxt_s = 1'b0;
                    valid_nxt_s = 1'b0;
                    div_nxt_s   = 17'd0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            idx_r   <= 4'd0;
            half_r  <= 17'd0;
            div_r   <= 17'd0;
            audio_r <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            half_r  <= half_nxt_s;
            div_r   <= div_nxt_s;
            audio_r <= audio_nxt_s;
            valid_r <= valid_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign audio_out  = audio_r;
    assign note_idx   = idx_r;
    assign note_valid = valid_r;
    assign seq_done   = done_r;

endmodule

// File: tb/tb_stacc_tone_player.sv
// -----------------------------------------------------------------------------
// tb_stacc_tone_player
// Directed bench for stacc_tone_player with HALF_SHIFT=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stacc_tone_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       gate_in;
    logic       audio_out;
    logic [3:0] note_idx;
    logic       note_valid;
    logic       seq_done;

    int tests_run    = 0;
    int tests_failed = 0;

    stacc_tone_player #(
        .NUM_NOTES (16),
        .HALF_SHIFT(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .gate_in   (gate_in),
        .audio_out (audio_out),
        .note_idx  (note_idx),
        .note_valid(note_valid),
        .seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    task automatic pulse_gate(input int hi, input int lo);
        gate_in = 1'b1;
        repeat (hi) @(negedge clk);
        gate_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Counts consecutive falling-edge samples where audio_out equals lvl (bounded).
    task automatic count_level(input logic lvl, output int cnt);
        cnt = 0;
        while (audio_out === lvl && cnt < 8000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        gate_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b0) begin tests_failed++; $display("FAIL reset_audio got %b want 0", audio_out); end
        tests_run++;
        if (note_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_idx got %0d want 0", note_idx); end
        tests_run++;
        if (note_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", note_valid); end
        tests_run++;
        if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", seq_done); end
    endtask

    task automatic test_first_note();
        int hi_cnt;
        int lo_cnt;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        gate_in = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b0) begin tests_failed++; $display("FAIL first_early got %b want 0", audio_out); end
        @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b1) begin tests_failed++; $display("FAIL first_high got %b want 1", audio_out); end
        tests_run++;
        if (note_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid got %b want 1", note_valid); end
        count_level(1'b1, hi_cnt);
        count_level(1'b0, lo_cnt);
        tests_run++;
        if (hi_cnt !== 5972) begin tests_failed++; $display("FAIL note0_high got %0d want 5972", hi_cnt); end
        tests_run++;
        if (hi_cnt + lo_cnt !== 11944) begin tests_failed++; $display("FAIL note0_period got %0d want 11944", hi_cnt + lo_cnt); end
        gate_in = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (note_idx !== 4'd0) begin tests_failed++; $display("FAIL fall_early_idx got %0d want 0", note_idx); end
        @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b0) begin tests_failed++; $display("FAIL fall_audio got %b want 0", audio_out); end
        tests_run++;
        if (note_idx !== 4'd1) begin tests_failed++; $display("FAIL fall_idx got %0d want 1", note_idx); end
        tests_run++;
        if (note_valid !== 1'b0) begin tests_failed++; $display("FAIL fall_valid got %b want 0", note_valid); end
    endtask

    task automatic test_rest();
        logic loud;
        for (int i = 0; i < 7; i++) pulse_gate(10, 10);
        tests_run++;
        if (note_idx !== 4'd8) begin tests_failed++; $display("FAIL step_to_rest got %0d want 8", note_idx); end
        loud = 1'b0;
        gate_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (audio_out !== 1'b0 || note_valid !== 1'b0) loud = 1'b1;
        end
        tests_run++;
        if (loud !== 1'b0) begin tests_failed++; $display("FAIL rest_silent got %b want 0", loud); end
        gate_in = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (note_idx !== 4'd9) begin tests_failed++; $display("FAIL rest_advance got %0d want 9", note_idx); end
    endtask

    task automatic test_enable_drop();
        int hi_cnt;
        pulse_reset();
        for (int i = 0; i < 5; i++) pulse_gate(10, 10);
        gate_in = 1'b1;
        repeat (10) @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b1) begin tests_failed++; $display("FAIL note5_sounding got %b want 1", audio_out); end
        enable = 1'b0;
        @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b0) begin tests_failed++; $display("FAIL disable_audio got %b want 0", audio_out); end
        tests_run++;
        if (note_valid !== 1'b0) begin tests_failed++; $display("FAIL disable_valid got %b want 0", note_valid); end
        gate_in = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (note_idx !== 4'd5) begin tests_failed++; $display("FAIL disable_idx got %0d want 5", note_idx); end
        enable = 1'b1;
        repeat (3) @(negedge clk);
        gate_in = 1'b1;
        repeat (3) @(negedge clk);
        count_level(1'b1, hi_cnt);
        tests_run++;
        if (hi_cnt !== 3551) begin tests_failed++; $display("FAIL note5_half got %0d want 3551", hi_cnt); end
        gate_in = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (note_idx !== 4'd6) begin tests_failed++; $display("FAIL note5_advance got %0d want 6", note_idx); end
    endtask

    task automatic test_sequence_end();
        logic loud;
        pulse_reset();
        for (int i = 0; i < 15; i++) pulse_gate(8, 8);
        tests_run++;
        if (note_idx !== 4'd15) begin tests_failed++; $display("FAIL seq_idx15 got %0d want 15", note_idx); end
        tests_run++;
        if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL seq_done_early got %b want 0", seq_done); end
        pulse_gate(8, 8);
`ifdef STACC_LOOP_EN
        tests_run++;
        if (note_idx !== 4'd0) begin tests_failed++; $display("FAIL wrap_idx got %0d want 0", note_idx); end
        tests_run++;
        if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL wrap_done got %b want 0", seq_done); end
`else
        tests_run++;
        if (note_idx !== 4'd15) begin tests_failed++; $display("FAIL end_idx got %0d want 15", note_idx); end
        tests_run++;
        if (seq_done !== 1'b1) begin tests_failed++; $display("FAIL end_done got %b want 1", seq_done); end
        loud = 1'b0;
        gate_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (audio_out !== 1'b0 || note_valid !== 1'b0) loud = 1'b1;
        end
        gate_in = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (loud !== 1'b0) begin tests_failed++; $display("FAIL done_silent got %b want 0", loud); end
        tests_run++;
        if (note_idx !== 4'd15) begin tests_failed++; $display("FAIL done_idx_hold got %0d want 15", note_idx); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (note_idx !== 4'd0) begin tests_failed++; $display("FAIL done_exit_idx got %0d want 0", note_idx); end
        tests_run++;
        if (seq_done !== 1'b0) begin tests_failed++; $display("FAIL done_exit_flag got %b want 0", seq_done); end
        enable = 1'b1;
`endif
    endtask

    task automatic test_reset_mid_sound();
        logic loud;
        pulse_reset();
        pulse_gate(10, 10);
        gate_in = 1'b1;
        repeat (50) @(negedge clk);
        tests_run++;
        if (audio_out !== 1'b1 || note_idx !== 4'd1) begin
            tests_failed++;
            $display("FAIL pre_reset got audio=%b idx=%0d want audio=1 idx=1", audio_out, note_idx);
        end
        #2;
        reset   = 1'b1;
        gate_in = 1'b0;
        #1;
        tests_run++;
        if (audio_out !== 1'b0) begin tests_failed++; $display("FAIL async_audio got %b want 0", audio_out); end
        tests_run++;
        if (note_idx !== 4'd0) begin tests_failed++; $display("FAIL async_idx got %0d want 0", note_idx); end
        tests_run++;
        if (note_valid !== 1'b0) begin tests_failed++; $display("FAIL async_valid got %b want 0", note_valid); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        loud  = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (audio_out !== 1'b0) loud = 1'b1;
        end
        tests_run++;
        if (loud !== 1'b0) begin tests_failed++; $display("FAIL post_reset_quiet got %b want 0", loud); end
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        gate_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_note();
        test_rest();
        test_enable_drop();
        test_sequence_end();
        test_reset_mid_sound();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
